// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: M-stage req/ack data-memory controller with lane steering, load extension, stall and error pulses.
module mem_stage_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemTypeM,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] ReadData2M,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWData,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AlignErr,
  output logic        BusErr
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic valid, isHalf, isByte, isWord, misaligned, start, timeout;
  logic [3:0] byteEn;
  logic [31:0] wData, shifted, loadData;
  assign valid = MemReadM | MemWriteM;
  assign isHalf = MemTypeM == 2'b01;
  assign isByte = MemTypeM == 2'b10;
  assign isWord = !isHalf && !isByte;
  assign misaligned = (isHalf && ALUresultM[0]) || (isWord && |ALUresultM[1:0]);
  assign start = state == IDLE && valid && !misaligned;
  // An ack on the terminal count wins over the abort.
  assign timeout = state == BUSY && !MemAck && cnt == CNT_W'(TIMEOUT - 1);
  assign StallM = !Reset && (start || state == BUSY);
  always_comb begin
    byteEn = isWord ? 4'hF : isHalf ? (ALUresultM[1] ? 4'hC : 4'h3) : 4'b0001 << ALUresultM[1:0];
    wData = isWord ? ReadData2M : isHalf ? {2{ReadData2M[15:0]}} : {4{ReadData2M[7:0]}};
    shifted = MemRData >> {(isHalf ? {ALUresultM[1], 1'b0} : ALUresultM[1:0]), 3'b000};
    loadData = isWord ? MemRData : isHalf ? {{16{shifted[15]}}, shifted[15:0]} : {{24{shifted[7]}}, shifted[7:0]};
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      MemReq <= 1'b0;
      MemWe <= 1'b0;
      MemAddr <= '0;
      MemByteEn <= '0;
      MemWData <= '0;
      ReadDataM <= '0;
      AlignErr <= 1'b0;
      BusErr <= 1'b0;
    end else begin
      AlignErr <= state == IDLE && valid && misaligned;
      BusErr <= timeout;
      if (start) begin
        MemReq <= 1'b1;
        MemWe <= MemWriteM;
        MemAddr <= {ALUresultM[31:2], 2'b00};
        MemByteEn <= byteEn;
        MemWData <= wData;
        cnt <= '0;
        state <= BUSY;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (MemAck || timeout) begin
          MemReq <= 1'b0;
          MemWe <= 1'b0;
          state <= DONE;
          if (timeout) ReadDataM <= '0;
          else if (MemReadM) ReadDataM <= loadData;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
